// File: rtl/timer.sv
// Qualification timer: hit_target asserts once `in` has been continuously
// high for `target` rising edges; any low cycle restarts the measurement.
module timer #(
    parameter int WIDTH = 21
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] target,
    input  logic             in,
    output logic             hit_target
);

    localparam logic [WIDTH-1:0] COUNT_MAX = '1;
    localparam logic [WIDTH-1:0] COUNT_ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    // Saturate at all-ones so a target of all-ones stays reachable.
    always_comb begin
        count_d = count_q;
        if (!in) begin
            count_d = '0;
        end else if (count_q != COUNT_MAX) begin
            count_d = count_q + COUNT_ONE;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign hit_target = in && (count_q >= target);

endmodule

// File: tb/tb_timer.sv
// Directed bench for timer at WIDTH=4: a per-cycle vector table plus
// hand-written multi-cycle sequences (latency, glitch, saturation, async reset).
module tb_timer;

    localparam int WIDTH = 4;

    logic             clk;
    logic             reset_s;
    logic [WIDTH-1:0] target_s;
    logic             in_s;
    logic             hit;

    int compared;
    int mismatched;

    typedef struct {
        logic             rst;
        logic [WIDTH-1:0] tgt;
        logic             inp;
        logic             exp_hit;
    } vec_t;

    vec_t vecs [19];

    timer #(.WIDTH(WIDTH)) dut (
        .clk        (clk),
        .reset      (reset_s),
        .target     (target_s),
        .in         (in_s),
        .hit_target (hit)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic applyStimulus(input logic r, input logic [WIDTH-1:0] t, input logic i);
        reset_s  = r;
        target_s = t;
        in_s     = i;
    endtask

    task automatic checkOutput(input logic exp_hit, input string name);
        compared++;
        if (hit !== exp_hit) begin
            mismatched++;
            $display("[TB] FAIL %s: hit_target=%b expected %b (t=%0t)", name, hit, exp_hit, $time);
        end
    endtask

    initial begin
        compared   = 0;
        mismatched = 0;
        applyStimulus(1'b1, 4'd8, 1'b0);

        // Per-cycle vectors: inputs driven at negedge, checked 1 time unit later;
        // the count seen by each row is the result of the previous rows' edges.
        vecs[0]  = '{1'b1, 4'd8, 1'b0, 1'b0};
        vecs[1]  = '{1'b1, 4'd0, 1'b1, 1'b1};
        vecs[2]  = '{1'b0, 4'd8, 1'b0, 1'b0};
        vecs[3]  = '{1'b0, 4'd0, 1'b1, 1'b1};
        vecs[4]  = '{1'b0, 4'd0, 1'b0, 1'b0};
        vecs[5]  = '{1'b0, 4'd0, 1'b1, 1'b1};
        vecs[6]  = '{1'b0, 4'd2, 1'b1, 1'b0};
        vecs[7]  = '{1'b0, 4'd2, 1'b1, 1'b1};
        vecs[8]  = '{1'b0, 4'd5, 1'b1, 1'b0};
        vecs[9]  = '{1'b0, 4'd5, 1'b1, 1'b0};
        vecs[10] = '{1'b0, 4'd5, 1'b1, 1'b1};
        vecs[11] = '{1'b0, 4'd3, 1'b1, 1'b1};
        vecs[12] = '{1'b0, 4'd7, 1'b1, 1'b1};
        vecs[13] = '{1'b0, 4'd9, 1'b1, 1'b0};
        vecs[14] = '{1'b0, 4'd9, 1'b0, 1'b0};
        vecs[15] = '{1'b0, 4'd1, 1'b1, 1'b0};
        vecs[16] = '{1'b0, 4'd1, 1'b1, 1'b1};
        vecs[17] = '{1'b0, 4'd1, 1'b0, 1'b0};
        vecs[18] = '{1'b0, 4'd0, 1'b0, 1'b0};

        for (int v = 0; v < 19; v++) begin
            @(negedge clk);
            applyStimulus(vecs[v].rst, vecs[v].tgt, vecs[v].inp);
            #1;
            checkOutput(vecs[v].exp_hit, $sformatf("vec%0d", v));
        end

        // Reset pulse then in low for 20 cycles.
        @(negedge clk);
        applyStimulus(1'b1, 4'd8, 1'b0);
        #2;
        applyStimulus(1'b0, 4'd8, 1'b0);
        for (int k = 1; k <= 20; k++) begin
            @(posedge clk); #1;
            checkOutput(1'b0, $sformatf("idle_e%0d", k));
        end

        // Held high: asserts at edge 8, stays up, count saturates.
        @(negedge clk);
        applyStimulus(1'b0, 4'd8, 1'b1);
        for (int k = 1; k <= 30; k++) begin
            @(posedge clk); #1;
            checkOutput(k >= 8, $sformatf("rise_e%0d", k));
        end
        @(negedge clk);
        applyStimulus(1'b0, 4'd15, 1'b1);
        #1;
        checkOutput(1'b1, "sat_now");
        for (int k = 1; k <= 20; k++) begin
            @(posedge clk); #1;
            checkOutput(1'b1, $sformatf("sat_e%0d", k));
        end

        // Drop in: same-cycle deassert, count cleared by the next edge.
        @(negedge clk);
        applyStimulus(1'b0, 4'd8, 1'b0);
        #1;
        checkOutput(1'b0, "drop_same_cycle");
        @(negedge clk);
        applyStimulus(1'b0, 4'd1, 1'b1);
        #1;
        checkOutput(1'b0, "drop_count_zero");
        @(posedge clk); #1;
        checkOutput(1'b1, "drop_count_one");

        // Glitch: 5 high, 1 low, then a full 8 edges are needed again.
        @(negedge clk);
        applyStimulus(1'b0, 4'd8, 1'b0);
        @(negedge clk);
        applyStimulus(1'b0, 4'd8, 1'b1);
        for (int k = 1; k <= 5; k++) begin
            @(posedge clk); #1;
            checkOutput(1'b0, $sformatf("glitch_pre_e%0d", k));
        end
        @(negedge clk);
        applyStimulus(1'b0, 4'd8, 1'b0);
        #1;
        checkOutput(1'b0, "glitch_low");
        @(negedge clk);
        applyStimulus(1'b0, 4'd8, 1'b1);
        for (int k = 1; k <= 10; k++) begin
            @(posedge clk); #1;
            checkOutput(k >= 8, $sformatf("glitch_post_e%0d", k));
        end

        // Async reset between edges with count=5.
        @(negedge clk);
        applyStimulus(1'b0, 4'd8, 1'b0);
        @(negedge clk);
        applyStimulus(1'b0, 4'd8, 1'b1);
        for (int k = 1; k <= 5; k++) begin
            @(posedge clk); #1;
            checkOutput(1'b0, $sformatf("arst_pre_e%0d", k));
        end
        @(negedge clk);
        applyStimulus(1'b0, 4'd5, 1'b1);
        #1;
        checkOutput(1'b1, "arst_count5");
        #2;
        applyStimulus(1'b1, 4'd5, 1'b1);
        #1;
        checkOutput(1'b0, "arst_immediate");
        applyStimulus(1'b1, 4'd0, 1'b1);
        #1;
        checkOutput(1'b1, "arst_target0");
        applyStimulus(1'b1, 4'd8, 1'b1);
        @(negedge clk);
        applyStimulus(1'b0, 4'd8, 1'b1);
        for (int k = 1; k <= 10; k++) begin
            @(posedge clk); #1;
            checkOutput(k >= 8, $sformatf("arst_post_e%0d", k));
        end

        // target = all-ones asserts after exactly 15 edges.
        @(negedge clk);
        applyStimulus(1'b0, 4'd15, 1'b0);
        @(negedge clk);
        applyStimulus(1'b0, 4'd15, 1'b1);
        for (int k = 1; k <= 16; k++) begin
            @(posedge clk); #1;
            checkOutput(k >= 15, $sformatf("max_e%0d", k));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
